quad_encoder_array: RTL and testbench
=====================================

# quad_encoder_array

Multi-channel quadrature decoder for the servo position path. It extends the single-channel encoder count with:
- per-channel glitch filtering
- illegal-transition detection
- software preload of the count (homing)
- windowed signed velocity measurement

It sits between the encoder pins and the PS-facing register bank. Counts start mid-range so the PS can compute position from differences captured during homing.

## Interface
- CHANNELS, 2, number of independent encoder channels
- WIDTH, 16, bit width of each count and velocity value
- COUNT_MAX, 64000, count modulus; legal counts are 0..COUNT_MAX-1, with COUNT_MAX ≤ 2^WIDTH
- FILTER_LEN, 4, consecutive cycles a synchronised input must differ before the filtered level changes; ≥1
- VEL_WINDOW, 100000, velocity sample window in clk cycles; ≥2
- clk  in  1  system clock; all logic on its rising edge
- rst  in  1  asynchronous, active-low reset
- A  in  CHANNELS  raw encoder phase A, one bit per channel, asynchronous to clk
- B  in  CHANNELS  raw encoder phase B, one bit per channel
- load  in  CHANNELS  per-channel one-cycle preload strobe
- load_value  in  WIDTH  preload value shared by all channels; must be < COUNT_MAX
- err_clear  in  CHANNELS  per-channel clear of the sticky error flag
- count  out  CHANNELS*WIDTH  flat counts; channel i occupies [i*WIDTH +: WIDTH]
- dir  out  CHANNELS  last step direction per channel: 1 = forward, 0 = backward
- err  out  CHANNELS  sticky illegal-transition flag per channel
- velocity  out  CHANNELS*WIDTH  signed two's-complement step count per window, same packing as count
- vel_valid  out  1  one-cycle pulse when velocity updates

## Operation
- **Reset (rst=0, async)**
  - every count = COUNT_MAX/2; velocity = 0; dir = 0; err = 0; vel_valid = 0
  - sync, filter and prev registers cleared to 0; window counter = 0; accumulators = 0
- **Per channel, input conditioning**
  - 2-FF synchroniser on A and B.
  - Independent filter per phase. When the synced bit ≠ the filtered bit, the run counter increments. When the run counter reaches FILTER_LEN-1, the filtered bit takes the synced value and the run counter returns to 0. When the synced bit = the filtered bit, the run counter returns to 0.
- **Decode**
  - Decode vector = {prevA, prevB, fA, fB}. prev registers load the filtered bits every cycle.
  - Forward: 0001, 0111, 1110, 1000. The count increments, wrapping COUNT_MAX-1 → 0. Set dir=1.
  - Backward: 0010, 1011, 1101, 0100. The count decrements, wrapping 0 → COUNT_MAX-1. Set dir=0.
  - Illegal (both bits change): 0011, 0110, 1001, 1100. Set err=1; count and dir are unchanged; the accumulator is unchanged.
  - No change: nothing happens.
- **Load**
  - load[i]=1 sets count[i] ← load_value and overrides any step in the same cycle.
  - dir, err and the velocity accumulator are unaffected; the step is still accumulated.
- **err_clear**
  - err_clear[i] clears err[i].
  - If an illegal transition occurs in the same cycle, set wins and err stays 1.
- **Velocity**
  - The shared window counter runs 0..VEL_WINDOW-1 and wraps.
  - Each channel has a signed WIDTH accumulator: +1 on a forward step, -1 on a backward step, saturating at 2^(WIDTH-1)-1 and -2^(WIDTH-1).
  - On the cycle the window counter equals VEL_WINDOW-1:
    - velocity[i] ← accumulator including this cycle's step, saturated
    - accumulator ← 0
    - vel_valid = 1 on the next cycle only
  - Count wrap and load do not affect velocity.

## Timing
- Input-to-count latency, for an input level stable before clk edge 0:
  - sync stage 1 at edge 0, sync stage 2 at edge 1
  - filtered bit at edge 1+FILTER_LEN
  - count and dir update at edge 2+FILTER_LEN (edge 6 at the default)
- A glitch shorter than FILTER_LEN cycles at the synchroniser output produces no count change.
- Maximum tracked edge rate is one edge per FILTER_LEN+1 cycles per phase.
- load to count: count valid the cycle after the load edge, i.e. one-cycle latency.
- err is visible one cycle after the illegal vector. err_clear has one-cycle latency.
- velocity and vel_valid update together. The first vel_valid after reset occurs VEL_WINDOW cycles after rst deasserts.
- Reset asserted mid-window discards the accumulator and restarts the window from 0.
- Channels are fully independent except for load_value and the window counter.

## Test plan
- **Reset and forward:** release rst, CHANNELS=2, FILTER_LEN=4. Drive ch0 AB 00→01→11→10→00 with 10-cycle steps -> count0 = 32004, dir0=1, count1 = 32000; each step lands 6 edges after its input change.
- **Wrap:** load ch0 = 0, then one backward step -> count0 = 63999; load 63999, then one forward step -> 0.
- **Glitch filter:** a 3-cycle pulse on A0 -> count unchanged, err0=0; the same pulse held for 4 cycles -> count +1.
- **Illegal transition:** AB 00→11 held -> err1=1, count1 unchanged. Assert err_clear1 together with a further illegal 11→00 -> err1 stays 1; a later err_clear1 alone -> 0.
- **Velocity:** VEL_WINDOW=100, 7 forward steps within one window -> vel_valid pulse, velocity0 = 7. Next window with 3 backward steps -> velocity0 = -3 (0xFFFD). A load mid-window leaves velocity unchanged.
- **Load vs step:** load ch0 with 1234 on the same edge as a forward step -> count0 = 1234, velocity window still counts +1.

Source files
------------

// File: rtl/quad_encoder_array.sv
// Multi-channel quadrature decoder: synchronises and glitch-filters each A/B pair, decodes
// steps into wrapping position counts, flags illegal transitions and measures windowed velocity.
module quad_encoder_array #(
   parameter int unsigned CHANNELS   = 2,
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned COUNT_MAX  = 64000,
   parameter int unsigned FILTER_LEN = 4,
   parameter int unsigned VEL_WINDOW = 100000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CHANNELS-1:0]       A,
   input  logic [CHANNELS-1:0]       B,
   input  logic [CHANNELS-1:0]       load,
   input  logic [WIDTH-1:0]          load_value,
   input  logic [CHANNELS-1:0]       err_clear,
   output logic [CHANNELS*WIDTH-1:0] count,
   output logic [CHANNELS-1:0]       dir,
   output logic [CHANNELS-1:0]       err,
   output logic [CHANNELS*WIDTH-1:0] velocity,
   output logic                      vel_valid
);

   localparam int unsigned RunW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam int unsigned WinW = $clog2(VEL_WINDOW);

   localparam logic [RunW-1:0]  RunLast  = RunW'(FILTER_LEN - 1);
   localparam logic [WinW-1:0]  WinLast  = WinW'(VEL_WINDOW - 1);
   localparam logic [WIDTH-1:0] CountTop = WIDTH'(COUNT_MAX - 1);
   localparam logic [WIDTH-1:0] CountMid = WIDTH'(COUNT_MAX / 2);
   localparam logic [WIDTH-1:0] AccMax   = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] AccMin   = {1'b1, {(WIDTH-1){1'b0}}};

   // Shared velocity window counter
   logic [WinW-1:0] win_q, win_d;
   logic            win_end;
   logic            vel_valid_q;

   assign win_end = (win_q == WinLast);

   always_comb begin
      win_d = win_end ? '0 : win_q + WinW'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         win_q       <= '0;
         vel_valid_q <= 1'b0;
      end else begin
         win_q       <= win_d;
         vel_valid_q <= win_end;
      end
   end

   assign vel_valid = vel_valid_q;

   for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
      logic [1:0]       raw;
      logic [1:0]       filt;
      logic [1:0]       prev_q;
      logic [3:0]       vec;
      logic             fwd, bwd, ill;
      logic [WIDTH-1:0] cnt_q, cnt_d;
      logic             dir_q, dir_d;
      logic             err_q, err_d;
      logic [WIDTH-1:0] acc_q, acc_d, acc_step;
      logic [WIDTH-1:0] vel_q, vel_d;

      // Bit 1 carries phase A, bit 0 phase B
      assign raw = {A[ch], B[ch]};

      for (genvar ph = 0; ph < 2; ph++) begin : g_ph
         logic            sync1_q, sync2_q;
         logic            filt_q, filt_d;
         logic [RunW-1:0] run_q, run_d;

         always_comb begin
            filt_d = filt_q;
            run_d  = '0;
            if (sync2_q != filt_q) begin
               if (run_q == RunLast) begin
                  filt_d = sync2_q;
               end else begin
                  run_d = run_q + RunW'(1);
               end
            end
         end

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               sync1_q <= 1'b0;
               sync2_q <= 1'b0;
               filt_q  <= 1'b0;
               run_q   <= '0;
            end else begin
               sync1_q <= raw[ph];
               sync2_q <= sync1_q;
               filt_q  <= filt_d;
               run_q   <= run_d;
            end
         end

         assign filt[ph] = filt_q;
      end

      assign vec = {prev_q, filt};

      always_comb begin
         fwd = 1'b0;
         bwd = 1'b0;
         ill = 1'b0;
         unique case (vec)
            4'b0001, 4'b0111, 4'b1110, 4'b1000: fwd = 1'b1;
            4'b0010, 4'b1011, 4'b1101, 4'b0100: bwd = 1'b1;
            4'b0011, 4'b0110, 4'b1001, 4'b1100: ill = 1'b1;
            default: ;
         endcase
      end

      // Load takes the count but a coincident step still moves dir and the accumulator
      always_comb begin
         cnt_d = cnt_q;
         if (load[ch]) begin
            cnt_d = load_value;
         end else if (fwd) begin
            cnt_d = (cnt_q == CountTop) ? '0 : cnt_q + WIDTH'(1);
         end else if (bwd) begin
            cnt_d = (cnt_q == '0) ? CountTop : cnt_q - WIDTH'(1);
         end
      end

      always_comb begin
         dir_d = dir_q;
         if (fwd) begin
            dir_d = 1'b1;
         end else if (bwd) begin
            dir_d = 1'b0;
         end
      end

      always_comb begin
         err_d = err_q;
         if (ill) begin
            err_d = 1'b1;
         end else if (err_clear[ch]) begin
            err_d = 1'b0;
         end
      end

      always_comb begin
         acc_step = acc_q;
         if (fwd && (acc_q != AccMax)) begin
            acc_step = acc_q + WIDTH'(1);
         end else if (bwd && (acc_q != AccMin)) begin
            acc_step = acc_q - WIDTH'(1);
         end
         acc_d = win_end ? '0 : acc_step;
         vel_d = win_end ? acc_step : vel_q;
      end

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            prev_q <= 2'b00;
            cnt_q  <= CountMid;
            dir_q  <= 1'b0;
            err_q  <= 1'b0;
            acc_q  <= '0;
            vel_q  <= '0;
         end else begin
            prev_q <= filt;
            cnt_q  <= cnt_d;
            dir_q  <= dir_d;
            err_q  <= err_d;
            acc_q  <= acc_d;
            vel_q  <= vel_d;
         end
      end

      assign count[ch*WIDTH +: WIDTH]    = cnt_q;
      assign velocity[ch*WIDTH +: WIDTH] = vel_q;
      assign dir[ch]                     = dir_q;
      assign err[ch]                     = err_q;
   end

endmodule

// File: tb/tb_quad_encoder_array.sv
// Directed and randomised bench for quad_encoder_array against a cycle-level behavioural model
// built from gray-code positions, delay histories and plain modular arithmetic.
module tb_quad_encoder_array;

   localparam int unsigned CH   = 2;
   localparam int unsigned W    = 16;
   localparam int unsigned CMAX = 64000;
   localparam int unsigned FL   = 4;
   localparam int unsigned VW   = 100;
   localparam int          AMAX = (2 ** (W - 1)) - 1;
   localparam int          AMIN = -(2 ** (W - 1));

   logic            clk = 1'b0;
   logic            rst;
   logic [CH-1:0]   a_in, b_in, load, err_clear;
   logic [W-1:0]    load_value;
   logic [CH*W-1:0] count, velocity;
   logic [CH-1:0]   dir, err;
   logic            vel_valid;

   int n_checks = 0;
   int n_errors = 0;

   // Behavioural model state
   int   m_count [CH];
   bit   m_dir   [CH];
   bit   m_err   [CH];
   int   m_acc   [CH];
   int   m_vel   [CH];
   bit   m_s1    [CH][2];
   bit   m_s2    [CH][2];
   bit   m_filt  [CH][2];
   bit   m_prev  [CH][2];
   int   m_run   [CH][2];
   bit   m_vv;
   int   m_win;
   int   t_rst;
   logic [1:0] gray [4];

   always #5 clk = ~clk;

   quad_encoder_array #(
      .CHANNELS  (CH),
      .WIDTH     (W),
      .COUNT_MAX (CMAX),
      .FILTER_LEN(FL),
      .VEL_WINDOW(VW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .A         (a_in),
      .B         (b_in),
      .load      (load),
      .load_value(load_value),
      .err_clear (err_clear),
      .count     (count),
      .dir       (dir),
      .err       (err),
      .velocity  (velocity),
      .vel_valid (vel_valid)
   );

   // Position of an AB level around the quadrature cycle 00 -> 01 -> 11 -> 10
   function automatic int gray_pos(bit a, bit b);
      return a ? (b ? 2 : 3) : (b ? 1 : 0);
   endfunction

   function automatic logic [31:0] cnt_of(int c);
      return 32'(count[c*W +: W]);
   endfunction

   function automatic logic [31:0] vel_of(int c);
      return 32'(velocity[c*W +: W]);
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < CH; c++) begin
         m_count[c] = CMAX / 2;
         m_dir[c]   = 1'b0;
         m_err[c]   = 1'b0;
         m_acc[c]   = 0;
         m_vel[c]   = 0;
         for (int p = 0; p < 2; p++) begin
            m_s1[c][p]   = 1'b0;
            m_s2[c][p]   = 1'b0;
            m_filt[c][p] = 1'b0;
            m_prev[c][p] = 1'b0;
            m_run[c][p]  = 0;
         end
      end
      m_vv  = 1'b0;
      m_win = 0;
      t_rst = 0;
   endtask

   // Advance the model by one rising edge using the inputs currently driven
   task automatic model_step();
      bit wend;
      bit raw;
      int d;
      wend = (m_win == VW - 1);
      for (int c = 0; c < CH; c++) begin
         d = (gray_pos(m_filt[c][0], m_filt[c][1]) - gray_pos(m_prev[c][0], m_prev[c][1]) + 4) % 4;
         if (d == 1) begin
            m_count[c] = (m_count[c] + 1) % CMAX;
            m_dir[c]   = 1'b1;
            m_acc[c]   = (m_acc[c] < AMAX) ? m_acc[c] + 1 : AMAX;
         end else if (d == 3) begin
            m_count[c] = (m_count[c] + CMAX - 1) % CMAX;
            m_dir[c]   = 1'b0;
            m_acc[c]   = (m_acc[c] > AMIN) ? m_acc[c] - 1 : AMIN;
         end
         if (load[c]) m_count[c] = int'(load_value);
         if (d == 2) m_err[c] = 1'b1;
         else if (err_clear[c]) m_err[c] = 1'b0;
         if (wend) begin
            m_vel[c] = m_acc[c];
            m_acc[c] = 0;
         end
         for (int p = 0; p < 2; p++) begin
            m_prev[c][p] = m_filt[c][p];
            raw = (p == 0) ? a_in[c] : b_in[c];
            if (m_s2[c][p] != m_filt[c][p]) begin
               m_run[c][p]++;
               if (m_run[c][p] == FL) begin
                  m_filt[c][p] = m_s2[c][p];
                  m_run[c][p]  = 0;
               end
            end else begin
               m_run[c][p] = 0;
            end
            m_s2[c][p] = m_s1[c][p];
            m_s1[c][p] = raw;
         end
      end
      m_vv  = wend;
      m_win = wend ? 0 : m_win + 1;
   endtask

   task automatic check_all(string tag);
      logic [W-1:0] ev;
      for (int c = 0; c < CH; c++) begin
         ev = W'(m_vel[c]);
         chk($sformatf("%s count%0d", tag, c), cnt_of(c), 32'(m_count[c]));
         chk($sformatf("%s dir%0d", tag, c), 32'(dir[c]), 32'(m_dir[c]));
         chk($sformatf("%s err%0d", tag, c), 32'(err[c]), 32'(m_err[c]));
         chk($sformatf("%s velocity%0d", tag, c), vel_of(c), 32'(ev));
      end
      chk($sformatf("%s vel_valid", tag), 32'(vel_valid), 32'(m_vv));
   endtask

   task automatic tick(string tag = "step");
      model_step();
      @(posedge clk);
      #1;
      t_rst++;
      check_all(tag);
   endtask

   task automatic ticks(int n, string tag = "step");
      for (int i = 0; i < n; i++) tick(tag);
   endtask

   task automatic set_ab(int c, logic [1:0] ab);
      a_in[c] = ab[1];
      b_in[c] = ab[0];
   endtask

   // Called just after a sampling point; asserts reset between clock edges
   task automatic apply_reset();
      #2 rst = 1'b0;
      model_reset();
      #1 check_all("async_reset");
      chk("reset count0", cnt_of(0), 32'd32000);
      chk("reset vel_valid", 32'(vel_valid), 32'd0);
      @(posedge clk);
      #1 check_all("reset_hold");
      #2 rst = 1'b1;
   endtask

   initial begin
      logic [1:0] ab;
      int         r;
      int         hold;

      gray[0] = 2'b00;
      gray[1] = 2'b01;
      gray[2] = 2'b11;
      gray[3] = 2'b10;
      rst        = 1'b0;
      a_in       = '0;
      b_in       = '0;
      load       = '0;
      err_clear  = '0;
      load_value = '0;
      model_reset();

      #13;
      check_all("por");
      chk("por count0", cnt_of(0), 32'd32000);
      chk("por count1", cnt_of(1), 32'd32000);
      chk("por velocity0", vel_of(0), 32'd0);
      rst = 1'b1;

      // Forward sequence on channel 0 with latency check on the first step
      set_ab(0, 2'b01);
      ticks(6, "fwd");
      chk("fwd latency hold", cnt_of(0), 32'd32000);
      tick("fwd");
      chk("fwd latency land", cnt_of(0), 32'd32001);
      ticks(3, "fwd");
      for (int k = 2; k <= 4; k++) begin
         set_ab(0, gray[k % 4]);
         ticks(10, "fwd");
      end
      chk("fwd count0", cnt_of(0), 32'd32004);
      chk("fwd dir0", 32'(dir[0]), 32'd1);
      chk("fwd count1", cnt_of(1), 32'd32000);

      // Wrap in both directions
      load_value = 16'd0;
      load[0] = 1'b1;
      tick("load");
      load[0] = 1'b0;
      chk("load zero", cnt_of(0), 32'd0);
      set_ab(0, 2'b10);
      ticks(10, "wrap");
      chk("wrap down", cnt_of(0), 32'd63999);
      chk("wrap down dir0", 32'(dir[0]), 32'd0);
      load_value = 16'd63999;
      load[0] = 1'b1;
      tick("load");
      load[0] = 1'b0;
      set_ab(0, 2'b00);
      ticks(10, "wrap");
      chk("wrap up", cnt_of(0), 32'd0);

      // Glitch filter: 3-cycle pulse rejected, 4-cycle pulse passes
      a_in[0] = 1'b1;
      ticks(3, "glitch");
      a_in[0] = 1'b0;
      ticks(10, "glitch");
      chk("glitch3 count0", cnt_of(0), 32'd0);
      chk("glitch3 err0", 32'(err[0]), 32'd0);
      b_in[0] = 1'b1;
      ticks(4, "pulse4");
      b_in[0] = 1'b0;
      ticks(3, "pulse4");
      chk("pulse4 count0", cnt_of(0), 32'd1);
      ticks(10, "pulse4");
      chk("pulse4 return", cnt_of(0), 32'd0);

      // Illegal transitions on channel 1, clear loses against a coincident set
      set_ab(1, 2'b11);
      ticks(10, "illegal");
      chk("illegal err1", 32'(err[1]), 32'd1);
      chk("illegal count1", cnt_of(1), 32'd32000);
      set_ab(1, 2'b00);
      ticks(6, "illegal");
      err_clear[1] = 1'b1;
      tick("illegal");
      err_clear[1] = 1'b0;
      chk("set beats clear", 32'(err[1]), 32'd1);
      ticks(5, "illegal");
      err_clear[1] = 1'b1;
      tick("clear");
      err_clear[1] = 1'b0;
      chk("clear err1", 32'(err[1]), 32'd0);
      chk("clear count1", cnt_of(1), 32'd32000);

      // Velocity windows aligned to a fresh reset
      apply_reset();
      for (int k = 1; k <= 7; k++) begin
         set_ab(0, gray[k % 4]);
         ticks(10, "vel");
      end
      ticks(29, "vel");
      chk("vel before window", 32'(vel_valid), 32'd0);
      tick("vel");
      chk("vel window1 valid", 32'(vel_valid), 32'd1);
      chk("vel window1 value", vel_of(0), 32'd7);
      tick("vel");
      chk("vel pulse width", 32'(vel_valid), 32'd0);
      for (int k = 1; k <= 3; k++) begin
         set_ab(0, gray[(7 - k) % 4]);
         ticks(10, "vel");
      end
      load_value = 16'd500;
      load[0] = 1'b1;
      tick("vel");
      load[0] = 1'b0;
      chk("vel load count0", cnt_of(0), 32'd500);
      chk("vel load keeps velocity", vel_of(0), 32'd7);
      ticks(67, "vel");
      tick("vel");
      chk("vel window2 valid", 32'(vel_valid), 32'd1);
      chk("vel window2 value", vel_of(0), 32'h0000_FFFD);

      // Load coinciding with a forward step
      set_ab(0, 2'b01);
      ticks(6, "ldstep");
      load_value = 16'd1234;
      load[0] = 1'b1;
      tick("ldstep");
      load[0] = 1'b0;
      chk("ldstep count0", cnt_of(0), 32'd1234);
      chk("ldstep dir0", 32'(dir[0]), 32'd1);
      ticks(92, "ldstep");
      tick("ldstep");
      chk("ldstep window valid", 32'(vel_valid), 32'd1);
      chk("ldstep velocity0", vel_of(0), 32'd1);

      // Randomised traffic: mostly legal steps, some jumps, short holds, loads and clears
      repeat (80) begin
         for (int c = 0; c < CH; c++) begin
            r = $urandom_range(9);
            if (r < 4) set_ab(c, gray[(gray_pos(a_in[c], b_in[c]) + 1) % 4]);
            else if (r < 7) set_ab(c, gray[(gray_pos(a_in[c], b_in[c]) + 3) % 4]);
            else if (r == 7) begin
               ab = 2'($urandom);
               set_ab(c, ab);
            end
         end
         hold = $urandom_range(9, 1);
         repeat (hold) begin
            load       = ($urandom_range(11) == 0) ? CH'($urandom) : '0;
            load_value = W'($urandom_range(CMAX - 1));
            err_clear  = ($urandom_range(5) == 0) ? CH'($urandom) : '0;
            tick("rand");
         end
      end
      load      = '0;
      err_clear = '0;

      // Reset mid-window restarts the window from zero
      ticks(37, "pre_reset");
      apply_reset();
      ticks(VW - 1, "post_reset");
      chk("restart no early valid", 32'(vel_valid), 32'd0);
      tick("post_reset");
      chk("restart valid at window", 32'(vel_valid), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
